// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, RGB565 field positions and the pipeline tag carried
// alongside each pixel while its frame-buffer read is in flight.
package vga_pkg;
  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int RD_LATENCY_DEF = 2;

  localparam int CW = 10;
  localparam int AW = 19;

  localparam int R_MSB = 15, R_LSB = 11;
  localparam int G_MSB = 10, G_LSB = 5;
  localparam int B_MSB = 4,  B_LSB = 0;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          act;
    logic          hs;
    logic          vs;
    logic          fst;
  } pix_tag_t;

  localparam pix_tag_t TAG_RST = '{x: '0, y: '0, act: 1'b0, hs: 1'b1, vs: 1'b1, fst: 1'b0};
endpackage

// File: rtl/vga_timing.sv
// Free-running h/v counters, raw syncs and frame-buffer address. The address
// holds its last active value through blanking.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          active,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          frame_start,
  output logic          v_end_start,
  output logic [AW-1:0] rd_addr
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW-1:0] LINE_W = AW'(H_ACTIVE);

  logic [AW-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      addr_q <= '0;
    end else begin
      addr_q <= rd_addr;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw      = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_raw      = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    v_end_start = (h_cnt == '0) && (v_cnt == V_ACT);
    rd_addr     = active ? (AW'(v_cnt) * LINE_W + AW'(h_cnt)) : addr_q;
  end
endmodule

// File: rtl/marker_pixel_source.sv
// Pixel source for the corner tracker: delays timing by the read latency,
// classifies each pixel against a per-frame colour key and counts matches.
module marker_pixel_source
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   rd_data,
  input  logic [4:0]    red_min,
  input  logic [5:0]    green_max,
  input  logic [4:0]    blue_max,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          pixel_valid,
  output logic [AW-1:0] frame_count,
  output logic          frame_done
);
  logic [CW-1:0] h_cnt, v_cnt;
  logic          active, hs_raw, vs_raw, frame_start, v_end_start;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .frame_start (frame_start),
    .v_end_start (v_end_start),
    .rd_addr     (rd_addr)
  );

  pix_tag_t      tag_now, tag_last;
  pix_tag_t      tag_pipe [RD_LATENCY];
  logic [4:0]    red_q, blue_q;
  logic [5:0]    green_q;
  logic          key_hit, valid_next;
  logic [AW-1:0] px_cnt;

  // The last tag stage lines up with the rd_data returned for that pixel.
  always_comb begin
    tag_now    = '{x: h_cnt, y: v_cnt, act: active, hs: hs_raw, vs: vs_raw, fst: v_end_start};
    tag_last   = tag_pipe[RD_LATENCY-1];
    key_hit    = (rd_data[R_MSB:R_LSB] >= red_q) &&
                 (rd_data[G_MSB:G_LSB] <= green_q) &&
                 (rd_data[B_MSB:B_LSB] <= blue_q);
    valid_next = tag_last.act && key_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= TAG_RST;
      red_q       <= 5'd31;
      green_q     <= '0;
      blue_q      <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_valid <= 1'b0;
      px_cnt      <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      tag_pipe[0] <= tag_now;
      for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      // Key is latched once per frame so a mid-frame change never splits a frame.
      if (frame_start) begin
        red_q   <= red_min;
        green_q <= green_max;
        blue_q  <= blue_max;
      end
      VGA_HS      <= tag_last.hs;
      VGA_VS      <= tag_last.vs;
      VGA_BLANK_N <= tag_last.act;
      pixel_x     <= tag_last.x;
      pixel_y     <= tag_last.y;
      pixel_valid <= valid_next;
      frame_done  <= tag_last.fst;
      if (tag_last.fst) begin
        frame_count <= px_cnt + AW'(valid_next);
        px_cnt      <= '0;
      end else begin
        px_cnt <= px_cnt + AW'(valid_next);
      end
    end
  end
endmodule

// File: tb/tb_marker_pixel_source.sv
// Directed bench on a shrunken 12x7 raster (8x4 active) with a 2-cycle RAM model.
module tb_marker_pixel_source;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [18:0] rd_addr;
  logic [15:0] rd_data, rd_d1;
  logic [4:0]  red_min = 5'd31;
  logic [5:0]  green_max = 6'd0;
  logic [4:0]  blue_max = 5'd0;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [9:0]  pixel_x, pixel_y;
  logic        pixel_valid;
  logic [18:0] frame_count;
  logic        frame_done;
  logic [15:0] mem [32];

  marker_pixel_source #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .RD_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .red_min(red_min), .green_max(green_max), .blue_max(blue_max),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .frame_count(frame_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_d1   <= mem[rd_addr[4:0]];
    rd_data <= rd_d1;
  end

  int errors = 0, checks = 0;
  int cyc = 0, pos_err = 0;
  int hs_low, vs_low, blank_hi, nvalid, ndone, fc_at_done, done_s;
  int first_vcyc, first_vx, first_vy, last_vx, last_vy, last_vcyc, addr19_cyc;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    hs_low = 0; vs_low = 0; blank_hi = 0; nvalid = 0; ndone = 0;
    fc_at_done = -1; done_s = -1; first_vcyc = -1; first_vx = -1; first_vy = -1;
    last_vx = -1; last_vy = -1; last_vcyc = -1; addr19_cyc = -1;
  endtask

  task automatic fill_mem(input logic [15:0] val);
    for (int i = 0; i < 32; i++) mem[i] = val;
  endtask

  // Outputs in cycle cyc belong to counter state cyc-3; earlier cycles show reset values.
  task automatic sample();
    int s, h, v, ex, ey;
    logic ehs, evs, ebl;
    s = cyc - 3;
    if (s < 0) begin
      ehs = 1'b1; evs = 1'b1; ebl = 1'b0; ex = 0; ey = 0;
    end else begin
      h = s % 12; v = (s / 12) % 7;
      ehs = !(h == 9 || h == 10); evs = (v != 5); ebl = (h < 8 && v < 4);
      ex = h; ey = v;
    end
    if (VGA_HS !== ehs || VGA_VS !== evs || VGA_BLANK_N !== ebl ||
        int'(pixel_x) != ex || int'(pixel_y) != ey || (s < 0 && pixel_valid)) pos_err++;
    if (!VGA_HS) hs_low++;
    if (!VGA_VS) vs_low++;
    if (VGA_BLANK_N) blank_hi++;
    if (pixel_valid) begin
      if (nvalid == 0) begin first_vcyc = cyc; first_vx = int'(pixel_x); first_vy = int'(pixel_y); end
      nvalid++;
      last_vx = int'(pixel_x); last_vy = int'(pixel_y); last_vcyc = cyc;
      if (!VGA_BLANK_N) pos_err++;
    end
    if (frame_done) begin
      ndone++;
      fc_at_done = int'(frame_count);
      done_s = (s < 0) ? -1 : s % 84;
    end
    if (rd_addr == 19'd19) addr19_cyc = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    fill_mem(16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hs", int'(VGA_HS), 1);
    chk("rst_vs", int'(VGA_VS), 1);
    chk("rst_blank", int'(VGA_BLANK_N), 0);
    chk("rst_valid", int'(pixel_valid), 0);
    chk("rst_x", int'(pixel_x), 0);
    chk("rst_y", int'(pixel_y), 0);
    chk("rst_addr", int'(rd_addr), 0);
    chk("rst_fcount", int'(frame_count), 0);
    chk("rst_fdone", int'(frame_done), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    run(3);

    // Timing: two frames of all-zero RAM under the no-match reset key
    for (int f = 0; f < 2; f++) begin
      clear_stats();
      run(60);
      if (f == 1) begin
        fill_mem(16'h0000);
        mem[19] = 16'hF800;
        red_min = 5'd16;
      end
      run(24);
      chk("tim_hs_low", hs_low, 14);
      chk("tim_vs_low", vs_low, 12);
      chk("tim_blank_hi", blank_hi, 32);
      chk("tim_valid", nvalid, 0);
      chk("tim_done", ndone, 1);
      chk("tim_done_pos", done_s, 48);
      chk("tim_fcount", fc_at_done, 0);
    end

    // Single match at address 19
    clear_stats();
    run(60);
    fill_mem(16'hF800);
    run(24);
    chk("one_valid", nvalid, 1);
    chk("one_x", last_vx, 3);
    chk("one_y", last_vy, 2);
    chk("one_latency", last_vcyc - addr19_cyc, 3);
    chk("one_done", ndone, 1);
    chk("one_fcount", fc_at_done, 1);

    // Full frame of red
    clear_stats();
    run(60);
    fill_mem(16'h07E0);
    run(24);
    chk("full_valid", nvalid, 32);
    chk("full_fcount", fc_at_done, 32);

    // Green frame: G=63 exceeds green_max=0
    clear_stats();
    run(84);
    chk("green_valid", nvalid, 0);
    chk("green_fcount", fc_at_done, 0);

    // Key opened at line 2: current frame unaffected
    clear_stats();
    run(21);
    red_min = 5'd0; green_max = 6'd63; blue_max = 5'd31;
    run(63);
    chk("keymid_valid", nvalid, 0);
    chk("keymid_fcount", fc_at_done, 0);

    clear_stats();
    run(84);
    chk("keynext_valid", nvalid, 32);
    chk("keynext_fcount", fc_at_done, 32);

    // Reset at line 2 pixel 5 while every pixel matches
    clear_stats();
    run(26);
    reset = 1'b1;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    clear_stats();
    @(negedge clk);
    sample();
    chk("mrst_hs", int'(VGA_HS), 1);
    chk("mrst_vs", int'(VGA_VS), 1);
    chk("mrst_blank", int'(VGA_BLANK_N), 0);
    chk("mrst_valid", int'(pixel_valid), 0);
    chk("mrst_x", int'(pixel_x), 0);
    chk("mrst_y", int'(pixel_y), 0);
    chk("mrst_addr", int'(rd_addr), 0);
    chk("mrst_fcount", int'(frame_count), 0);
    chk("mrst_fdone", int'(frame_done), 0);
    @(posedge clk);
    #1;
    cyc++;
    run(86);
    chk("mrst_first_cyc", first_vcyc, 3);
    chk("mrst_first_x", first_vx, 0);
    chk("mrst_first_y", first_vy, 0);
    chk("mrst_valid_cnt", nvalid, 32);
    chk("mrst_done", ndone, 1);
    chk("mrst_fcount_next", fc_at_done, 32);

    chk("raster_alignment", pos_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/marker_pixel_source.md
# marker_pixel_source

Transmit end of the pixel-stream interface consumed by the corner-tracking FSM. Generates 640x480 VGA timing and reads RGB565 pixels from the frame buffer. Classifies each active pixel against a colour-key window and drives `pixel_x`/`pixel_y`/`pixel_valid` and `VGA_VS`, aligned so the tracker sees every marker pixel of a frame before the falling edge of `VGA_VS`. Also reports a per-frame marker pixel count.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, `H_SYNC`, `H_BP`, 16/96/48, horizontal porch/sync widths
- `V_ACTIVE`, 480, visible lines
- `V_FP`, `V_SYNC`, `V_BP`, 10/2/33, vertical porch/sync widths
- `RD_LATENCY`, 2, frame-buffer read latency in cycles (1..4)

Ports:
- `clk` in 1: pixel clock, one pixel per cycle; the only clock
- `reset` in 1: synchronous, active-high
- `rd_addr` out 19: frame-buffer address, `y*H_ACTIVE + x`
- `rd_data` in 16: RGB565, valid `RD_LATENCY` cycles after `rd_addr`
- `red_min`, `green_max`, `blue_max` in 5/6/5: colour-key window
- `VGA_HS`, `VGA_VS` out 1: active-low syncs
- `VGA_BLANK_N` out 1: high during the active region
- `pixel_x` out 10 unsigned: column of the current pixel
- `pixel_y` out 10 unsigned: row of the current pixel
- `pixel_valid` out 1: current pixel matches the key
- `frame_count` out 19: marker pixels in the last completed frame
- `frame_done` out 1: one-cycle pulse when `frame_count` updates

## Operation
- Counters: `h_cnt` 0..H_TOTAL-1 and `v_cnt` 0..V_TOTAL-1.
  - `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800 by default); `V_TOTAL` likewise (525).
  - `h_cnt` wraps every line; `v_cnt` increments on the `h_cnt` wrap and wraps to 0 after `V_TOTAL-1`.
- Active region: `h_cnt < H_ACTIVE && v_cnt < V_ACTIVE`.
  - `rd_addr` is driven combinationally from the counters during the active region.
  - `rd_addr` holds its last value outside the active region.
- Sync windows:
  - HS is low for `H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC`.
  - VS is low for `V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC`; by default lines 490-491.
- Key match: `R >= red_min && G <= green_max && B <= blue_max`, where R=`rd_data[15:11]`, G=`[10:5]`, B=`[4:0]`.
  - Comparisons are unsigned.
  - A match qualifies only while the delayed active flag is set.
- Key registers:
  - Key inputs are captured into shadow registers on the cycle `h_cnt==0 && v_cnt==0`.
  - Mid-frame changes take effect next frame.
  - Reset loads the shadows with `red_min=31`, `green_max=0`, `blue_max=0`.
- Per-frame counting:
  - An internal 19-bit counter increments on each `pixel_valid` cycle. It cannot overflow: max 307200 < 2^19.
  - At the first output cycle with delayed `v_cnt==V_ACTIVE`, `h_cnt==0`:
    - `frame_count` takes the counter value, plus 1 if that same cycle is also a match (never, by construction);
    - the counter clears to 0;
    - `frame_done` pulses for one cycle.
- Reset mid-frame: restarts the counters at (0,0) and discards all in-flight pipeline stages. The first output after reset belongs to pixel (0,0) of a new frame.

## Timing
- Pipeline latency is `L = RD_LATENCY+1` cycles, from counter state to all outputs.
- `VGA_HS`, `VGA_VS`, `VGA_BLANK_N`, `pixel_x`, `pixel_y` and `pixel_valid` all pass through the same L-stage delay, so they are mutually aligned.
- `pixel_x`/`pixel_y` carry the delayed coordinates every cycle, including blanking. Consumers qualify them with `pixel_valid`.
- Reset values of all outputs:
  - `VGA_HS=1`, `VGA_VS=1`, `VGA_BLANK_N=0`
  - `pixel_valid=0`, `pixel_x=0`, `pixel_y=0`
  - `rd_addr=0`, `frame_count=0`, `frame_done=0`
  - All delay stages are also cleared.
- Ordering guarantees:
  - The `frame_done` pulse precedes the falling edge of `VGA_VS` by `V_FP` lines.
  - All `pixel_valid` cycles of a frame occur before that frame's `VGA_VS` fall.
- Throughput: one classified pixel per cycle, no stalls, no backpressure.

## Structure
- Shared package `vga_pkg`:
  - default timing localparams;
  - RGB565 field slice constants;
  - coordinate width (10);
  - address width (19).
- Sub-module `vga_timing`: h/v counters, active flag, raw HS/VS, and `rd_addr` generation.
- The top level holds the delay line, key shadows, comparator and frame counter.

## Test plan
Benches override timing to `H_ACTIVE=8`, `H_FP=1`, `H_SYNC=2`, `H_BP=1`, `V_ACTIVE=4`, `V_FP=1`, `V_SYNC=1`, `V_BP=1`, `RD_LATENCY=2`, with a behavioural RAM model.
- Timing: free-run 2 frames. Required:
  - `VGA_HS` low exactly 2 cycles per 12-cycle line;
  - `VGA_VS` low exactly line 5 of each 7-line frame;
  - `VGA_BLANK_N` high 32 cycles per frame.
- Single match: RAM all 0x0000 except addr 19 = 0xF800, key `red_min=16`. Required:
  - exactly one `pixel_valid`, with `pixel_x=3`, `pixel_y=2`, 3 cycles after `rd_addr=19`;
  - `frame_count=1` with a `frame_done` pulse.
- Full frame: RAM all 0xF800. Required: 32 `pixel_valid` cycles and `frame_count=32`. Then switch RAM to 0x07E0 and require `frame_count=0` next frame.
- Key change mid-frame: set `red_min=0`, `green_max=63`, `blue_max=31` at line 2. Required: the current frame's count is unchanged; the next frame counts 32.
- Reset mid-frame: assert `reset` at line 2 pixel 5 for 1 cycle. Required:
  - all outputs at their reset values the next cycle;
  - no `pixel_valid` from the pre-reset pipeline;
  - the first valid-window output is (0,0) at cycle L after reset release.
